// File: rtl/shift_pkg.sv
//------------------------------------------------------------------------------
// shift_pkg : shared types for the PISO transmitter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_pkg;

    // PARITY is always encoded so both build flavours share one state type.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    localparam int SHIFT_WIDTH_DEFAULT = 8;

    function automatic logic even_parity(input logic [SHIFT_WIDTH_DEFAULT-1:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_transmitter_bit_counter.sv
//------------------------------------------------------------------------------
// bit_counter : word-position counter, wraps to 0 after WIDTH-1. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic cl,
    input  logic r,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cl) begin
        if (r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso_shift_transmitter.sv
//------------------------------------------------------------------------------
// piso_shift_transmitter : valid/ready loaded, LSB-first serialiser.
// Optional trailing even-parity bit via macro PISO_PARITY_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_shift_transmitter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic             cl,
    input  logic             r,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parin,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             w_last;
    logic             w_xfer;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .cl     (cl),
        .r      (r),
        .clr_i  (w_xfer),
        .en_i   (state_q == SHIFT),
        .last_o (w_last)
    );

    assign w_xfer = load_valid && load_ready;

`ifdef PISO_PARITY_EN
    logic parity_q;

    always_ff @(posedge cl) begin
        if (r) begin
            parity_q <= 1'b0;
        end else if (w_xfer) begin
            parity_q <= ^parin;
        end
    end

    assign load_ready = (state_q == IDLE) || (state_q == PARITY);
    assign done       = (state_q == PARITY);
    assign sout       = (state_q == SHIFT)  ? shreg_q[0] :
                        (state_q == PARITY) ? parity_q   : 1'b0;
`else
    assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && w_last);
    assign done       = (state_q == SHIFT) && w_last;
    assign sout       = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
`endif

    assign sout_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    state_d = SHIFT;
                    shreg_d = parin;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                if (w_last) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    // A load on the final bit chains the next word with no gap.
                    if (w_xfer) begin
                        shreg_d = parin;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                if (w_xfer) begin
                    state_d = SHIFT;
                    shreg_d = parin;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cl) begin
        if (r) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_transmitter.sv
//------------------------------------------------------------------------------
// tb_piso_shift_transmitter : directed + random bench with a position model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_shift_transmitter;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int LAST = W;
`else
    localparam int LAST = W - 1;
`endif

    logic         cl = 1'b0;
    logic         r;
    logic         load_valid;
    logic [W-1:0] parin;
    logic         load_ready;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    int compared   = 0;
    int mismatched = 0;

    // Model: -1 when idle, else index of the bit on sout (W = parity bit).
    int           m_pos  = -1;
    logic [W-1:0] m_word = '0;

    logic [W-1:0] rx_q;
    logic         rx_chk;
    logic [W-1:0] rx_exp;

    piso_shift_transmitter #(
        .WIDTH (W)
    ) dut (
        .cl         (cl),
        .r          (r),
        .load_valid (load_valid),
        .parin      (parin),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 cl = ~cl;

    // Receiver on the same clock: LSB-first bits land in the MSB and shift down.
    always_ff @(posedge cl) rx_q <= {sout, rx_q[W-1:1]};

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_sout();
        if (m_pos < 0) return 1'b0;
        if (m_pos < W) return m_word[m_pos];
        return ^m_word;
    endfunction

    task automatic cyc(input logic rv, input logic lv, input logic [W-1:0] d, output logic xfer);
        logic ready;
        r          = rv;
        load_valid = lv;
        parin      = d;
        ready      = (m_pos == -1) || (m_pos == LAST);
        xfer       = !rv && lv && ready;
        rx_chk     = !rv && (m_pos == W - 1);
        rx_exp     = m_word;
        @(posedge cl);
        if (rv) begin
            m_pos = -1;
        end else if (xfer) begin
            m_word = d;
            m_pos  = 0;
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == LAST) ? -1 : m_pos + 1;
        end
        #1;
        chk("load_ready", W'(load_ready), W'((m_pos == -1) || (m_pos == LAST)));
        chk("sout",       W'(sout),       W'(exp_sout()));
        chk("sout_valid", W'(sout_valid), W'(m_pos >= 0));
        chk("busy",       W'(busy),       W'(m_pos >= 0));
        chk("done",       W'(done),       W'(m_pos == LAST));
        if (rx_chk) chk("rx_word", rx_q, rx_exp);
    endtask

    task automatic push(input logic [W-1:0] d);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            cyc(1'b0, 1'b1, d, x);
            if (x) break;
        end
        chk("push_accepted", W'(x), W'(1));
    endtask

    task automatic idle(input int n);
        logic x;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, W'($urandom), x);
    endtask

    initial begin
        logic         x;
        logic         lv;
        logic         rv;
        logic [W-1:0] d;
        bit           hold;

        // Reset with a pending load that must be ignored.
        cyc(1'b1, 1'b1, 8'hFF, x);
        cyc(1'b1, 1'b1, 8'hFF, x);
        idle(2);

        push(8'hA5);
        idle(W + 3);

        push(8'h3C);
        push(8'hC3);
        idle(W + 3);

        // Stall: offer a word mid-transfer.
        push(8'hA5);
        idle(2);
        push(8'h01);
        idle(W + 3);

        // Abort mid-word.
        push(8'hFF);
        idle(3);
        cyc(1'b1, 1'b0, 8'h00, x);
        idle(3);

        push(8'h07);
        idle(W + 3);
        push(8'h03);
        idle(W + 3);

        hold = 1'b0;
        lv   = 1'b0;
        d    = '0;
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 59) == 0);
            if (!hold) begin
                lv = ($urandom_range(0, 2) != 0);
                d  = W'($urandom);
            end
            cyc(rv, lv, d, x);
            hold = lv && !x && !rv;
        end
        idle(W + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piso_shift_transmitter.md
Name: piso_shift_transmitter

Overview:
- Parallel-in/serial-out transmitter; the sending end of the team's serial-in/parallel-out shift register (`shift_register2`).
- Accepts a WIDTH-bit word through a valid/ready load handshake and drives it out on `sout`, one bit per `cl` cycle, LSB first.
- After WIDTH shift cycles, a `shift_register2` clocked on the same `cl` holds the word with `parout == word`.
- Supports back-to-back words with no idle bubble, so a continuous stream feeds the receiver.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).

Ports:
- cl  input  1  clock; all state updates on rising edge.
- r  input  1  reset, synchronous, active-high.
- load_valid  input  1  producer has a word on `parin`.
- parin  input  WIDTH  word to transmit.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data, registered, LSB first.
- sout_valid  output  1  `sout` carries a valid bit this cycle.
- busy  output  1  a word is being shifted.
- done  output  1  one-cycle pulse on the cycle the final bit of a word is on `sout`.

Behaviour:
- Interface: one clock `cl`; reset `r` is synchronous and active-high.
- Reset (r=1 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
  - Reset overrides any load in the same cycle.
  - Reset mid-word aborts the word; no done pulse.
- Handshake:
  - A transfer occurs when load_valid && load_ready at a rising edge.
  - load_ready = (state==IDLE) || (state==SHIFT && last bit cycle), combinational from registered state only.
  - load_ready does not depend on load_valid.
  - parin is sampled only at the transfer edge.
- States:
  - IDLE: sout=0, sout_valid=0. Transfer -> SHIFT, shreg<=parin, cnt<=0.
  - SHIFT:
    - sout=shreg[0], sout_valid=1, busy=1.
    - Each edge: shreg<=shreg>>1, cnt<=cnt+1.
    - At cnt==WIDTH-1 (last bit cycle) done=1, and:
      - transfer in this cycle -> stay SHIFT, shreg<=parin, cnt<=0 (back-to-back, no gap);
      - no transfer -> IDLE.
- Latency: the bit of parin[0] appears on `sout` the first cycle after the transfer edge; parin[k] appears k+1 cycles after it.
- Word duration: exactly WIDTH cycles of sout_valid per word.
- Counter: $clog2(WIDTH) bits; never exceeds WIDTH-1; no wrap beyond the word.
- load_valid held high while load_ready is low: no effect; the producer must hold parin stable until the transfer.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Adds state PARITY after the last data bit: one extra cycle with sout = even parity (XOR of the word), sout_valid=1, busy=1.
  - done pulses in the PARITY cycle instead of the last data bit cycle.
  - load_ready is high in IDLE and in PARITY (not in the last data bit cycle).
  - Word duration is WIDTH+1 cycles.
  - Parity is computed and registered at load.
- Undefined: no PARITY state, no parity register; behaviour exactly as above.

Decomposition:
- Package `shift_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t` (PARITY encoded regardless of the macro);
  - `localparam int SHIFT_WIDTH_DEFAULT = 8`.
- Sub-module `bit_counter`:
  - parameter WIDTH; synchronous clear and enable; output `last` (cnt==WIDTH-1);
  - instantiated once for word position.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset: hold r=1 for 2 cycles with load_valid=1, parin=8'hFF -> sout=0, sout_valid=0, busy=0, load_ready=1; no transfer.
- Single word: load 8'hA5 in IDLE -> next 8 cycles sout = 1,0,1,0,0,1,0,1, sout_valid=1; done on the 8th; then IDLE. A `shift_register2` on the same `cl` with sin=sout shows parout=8'hA5 after 8 edges.
- Back-to-back: 8'h3C then 8'hC3 with load_valid held -> 16 consecutive sout_valid cycles, no gap. Bits 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1; done pulses at cycles 8 and 16.
- Stall: load_valid=1 with parin=8'h01 while mid-word (cycle 3) -> no transfer until the last bit cycle; current word bits are unchanged; 8'h01 follows immediately.
- Reset mid-word: load 8'hFF, assert r at bit cycle 4 -> next cycle sout=0, sout_valid=0, IDLE, no done pulse.
- PISO_PARITY_EN: load 8'h07 -> bits 1,1,1,0,0,0,0,0 then parity 1 (9 cycles); done on the 9th. Load 8'h03 -> parity bit 0.
